// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus: raw PS/2 lines in,
// held-key vectors and byte stream out.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] wsad_down;
  logic [3:0] arrow_down;
  logic [7:0] scan_byte;
  logic       byte_valid;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  wsad_down,
    input  arrow_down,
    input  scan_byte,
    input  byte_valid,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output wsad_down,
    output arrow_down,
    output scan_byte,
    output byte_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and WASD/arrow held-key
// decoder for the two-player movers.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst_n,
  ps2_key_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } pfx_t;

  localparam logic [16:0] TO_LAST =
    17'(TIMEOUT_CYCLES - 1);

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_prev;
  logic [10:0] shift_q;
  logic [3:0]  bit_cnt;
  logic [16:0] to_cnt;
  logic [7:0]  scan_q;
  logic        bv_q;
  logic        fe_q;
  pfx_t        state;
  logic [3:0]  wsad_q;
  logic [3:0]  arrow_q;

  logic        fall;
  logic [10:0] frame;
  logic        frame_ok;
  logic        make;
  logic        ext;

  assign fall     = clk_prev & ~clk_sync[1];
  assign frame    = {dat_sync[1], shift_q[10:1]};
  assign frame_ok = ~frame[0] & frame[10]
                  & (^frame[9:1]);
  assign make     = (state == IDLE) ||
                    (state == EXT);
  assign ext      = (state == EXT) ||
                    (state == EXT_BRK);

  // two-flop synchronizers plus edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_clk};
      dat_sync <= {dat_sync[0], bus.ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  // frame shifter, checker and idle timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      scan_q  <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      bv_q <= 1'b0;
      fe_q <= 1'b0;
      if (fall) begin
        shift_q <= frame;
        to_cnt  <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            scan_q <= frame[8:1];
            bv_q   <= 1'b1;
          end else begin
            fe_q <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt == 4'd0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt  <= '0;
        bit_cnt <= '0;
        fe_q    <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 17'd1;
      end
    end
  end

  // prefix FSM and held-key bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wsad_q  <= '0;
      arrow_q <= '0;
    end else if (bv_q) begin
      unique case (scan_q)
        8'hE0: state <= EXT;
        8'hF0: state <= ext ? EXT_BRK : BRK;
        default: begin
          state <= IDLE;
          if (!ext) begin
            unique case (scan_q)
              8'h1D:   wsad_q[0] <= make;
              8'h1C:   wsad_q[1] <= make;
              8'h1B:   wsad_q[2] <= make;
              8'h23:   wsad_q[3] <= make;
              default: ;
            endcase
          end else begin
            unique case (scan_q)
              8'h75:   arrow_q[0] <= make;
              8'h6B:   arrow_q[1] <= make;
              8'h72:   arrow_q[2] <= make;
              8'h74:   arrow_q[3] <= make;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.wsad_down  = wsad_q;
  assign bus.arrow_down = arrow_q;
  assign bus.scan_byte  = scan_q;
  assign bus.byte_valid = bv_q;
  assign bus.frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder:
// frames in, byte/error stream and key state out.
module tb_ps2_key_decoder;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] last_byte = 8'h00;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(
    input logic [7:0] b, input logic ok);
    logic p;
    p = ok ? ~^b : ^b;
    return {1'b1, p, b, 1'b0};
  endfunction

  // scoreboard: every byte_valid / frame_err
  // pulse must match the next queued event
  always @(negedge clk) begin
    if (rst_n && (bus.byte_valid || bus.frame_err)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event bv=%0b fe=%0b scan=%h",
                 bus.byte_valid, bus.frame_err, bus.scan_byte);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.frame_err, bus.byte_valid, bus.scan_byte}
            !== {mon_e[8], ~mon_e[8], mon_e[7:0]})
          $display("FAIL scoreboard got fe=%0b bv=%0b scan=%h want fe=%0b scan=%h",
                   bus.frame_err, bus.byte_valid, bus.scan_byte,
                   mon_e[8], mon_e[7:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic send_bits(input logic [10:0] f,
                           input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      bus.ps2_data = f[i];
      repeat (10) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic ok);
    if (ok) begin
      exp_q.push_back({1'b0, b});
      last_byte = b;
    end else begin
      exp_q.push_back({1'b1, last_byte});
    end
    send_bits(mk(b, ok), 0, 10);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({bus.wsad_down, bus.arrow_down, bus.scan_byte,
         bus.byte_valid, bus.frame_err} !== 18'd0)
      $display("FAIL reset_state got %h want 0",
               {bus.wsad_down, bus.arrow_down, bus.scan_byte,
                bus.byte_valid, bus.frame_err});
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_timing();
    logic [10:0] f;
    int n_bv, n_w, bv_cnt;
    f = mk(8'h1D, 1'b1);
    exp_q.push_back({1'b0, 8'h1D});
    last_byte = 8'h1D;
    send_bits(f, 0, 9);
    @(negedge clk);
    bus.ps2_data = f[10];
    repeat (10) @(negedge clk);
    bus.ps2_clk = 1'b0;
    n_bv = 0; n_w = 0; bv_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.byte_valid) begin
        bv_cnt++;
        if (n_bv == 0) n_bv = n;
      end
      if (bus.wsad_down == 4'b0001 && n_w == 0) n_w = n;
    end
    bus.ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if (n_bv !== 3)
      $display("FAIL bv_latency got %0d want 3", n_bv);
    else n_pass++;
    n_chk++;
    if (n_w !== 4)
      $display("FAIL key_latency got %0d want 4", n_w);
    else n_pass++;
    n_chk++;
    if (bv_cnt !== 1)
      $display("FAIL bv_pulse_len got %0d want 1", bv_cnt);
    else n_pass++;
    n_chk++;
    if (bus.scan_byte !== 8'h1D)
      $display("FAIL basic_scan got %h want 1d", bus.scan_byte);
    else n_pass++;
  endtask

  task automatic test_wasd();
    logic [7:0] seq [6] = '{8'h1D, 8'h23, 8'hF0,
                            8'h1D, 8'hF0, 8'h23};
    logic [3:0] ew  [6] = '{4'b0001, 4'b1001, 4'b1001,
                            4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      send_frame(seq[i], 1'b1);
      n_chk++;
      if (bus.wsad_down !== ew[i])
        $display("FAIL wasd_%0d got %b want %b",
                 i, bus.wsad_down, ew[i]);
      else n_pass++;
    end
  endtask

  task automatic test_arrows();
    logic [7:0] seq [11] = '{8'hE0, 8'h6B, 8'hE0, 8'hF0,
                             8'h6B, 8'hE0, 8'h1D, 8'h75,
                             8'hAA, 8'hFA, 8'hEE};
    logic [3:0] ea  [11] = '{4'b0000, 4'b0010, 4'b0010,
                             4'b0010, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000};
    for (int i = 0; i < 11; i++) begin
      send_frame(seq[i], 1'b1);
      n_chk++;
      if ({bus.arrow_down, bus.wsad_down} !== {ea[i], 4'b0000})
        $display("FAIL arrow_%0d got arrow=%b wsad=%b want arrow=%b wsad=0000",
                 i, bus.arrow_down, bus.wsad_down, ea[i]);
      else n_pass++;
    end
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b0);
    n_chk++;
    if ({bus.wsad_down, bus.scan_byte} !== {4'b0000, last_byte})
      $display("FAIL parity_hold got wsad=%b scan=%h want 0000 %h",
               bus.wsad_down, bus.scan_byte, last_byte);
    else n_pass++;
    send_frame(8'h1C, 1'b1);
    n_chk++;
    if (bus.wsad_down !== 4'b0010)
      $display("FAIL parity_recover got %b want 0010",
               bus.wsad_down);
    else n_pass++;
    send_frame(8'h1C, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b1);
    n_chk++;
    if (bus.wsad_down !== 4'b0000)
      $display("FAIL repeat_break got %b want 0000",
               bus.wsad_down);
    else n_pass++;
  endtask

  task automatic test_timeout();
    exp_q.push_back({1'b1, last_byte});
    send_bits(mk(8'h55, 1'b1), 0, 3);
    repeat (TO + 60) @(negedge clk);
    n_chk++;
    if (exp_q.size() !== 0)
      $display("FAIL timeout_err got pending=%0d want 0",
               exp_q.size());
    else n_pass++;
    send_frame(8'h1B, 1'b1);
    n_chk++;
    if (bus.wsad_down !== 4'b0100)
      $display("FAIL timeout_recover got %b want 0100",
               bus.wsad_down);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [10:0] f;
    send_frame(8'h1D, 1'b1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h23, 1'b1);
    n_chk++;
    if (bus.wsad_down !== 4'b1111)
      $display("FAIL all_held got %b want 1111", bus.wsad_down);
    else n_pass++;
    f = mk(8'h72, 1'b1);
    send_bits(f, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.wsad_down, bus.arrow_down, bus.scan_byte,
         bus.byte_valid, bus.frame_err} !== 18'd0)
      $display("FAIL midreset_clear got %h want 0",
               {bus.wsad_down, bus.arrow_down, bus.scan_byte,
                bus.byte_valid, bus.frame_err});
    else n_pass++;
    rst_n = 1'b1;
    last_byte = 8'h00;
    exp_q.push_back({1'b1, 8'h00});
    send_bits(f, 6, 10);
    repeat (TO + 60) @(negedge clk);
    n_chk++;
    if (bus.scan_byte !== 8'h00)
      $display("FAIL midreset_nobyte got %h want 00",
               bus.scan_byte);
    else n_pass++;
    send_frame(8'h23, 1'b1);
    n_chk++;
    if ({bus.wsad_down, bus.arrow_down, bus.scan_byte}
        !== {4'b1000, 4'b0000, 8'h23})
      $display("FAIL midreset_next got %b %b %h want 1000 0000 23",
               bus.wsad_down, bus.arrow_down, bus.scan_byte);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_timing();
    test_wasd();
    test_arrows();
    test_parity();
    test_timeout();
    test_mid_reset();
    repeat (10) @(negedge clk);
    n_chk++;
    if (exp_q.size() !== 0)
      $display("FAIL scoreboard_drain got %0d want 0",
               exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning idle clk cycles mid-frame before the frame is abandoned.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-006 SHALL have port wsad_down  output  4  held keys: [0]=W, [1]=A, [2]=S, [3]=D; feeds the blue-player mover.
REQ-007 SHALL have port arrow_down  output  4  held keys: [0]=Up, [1]=Left, [2]=Down, [3]=Right; feeds the red-player mover.
REQ-008 SHALL have port scan_byte  output  8  last correctly received byte.
REQ-009 SHALL have port byte_valid  output  1  one-cycle pulse when scan_byte updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect a ps2_clk falling edge when the synced prior value is 1 and the current value is 0.
REQ-012 SHALL sample synced ps2_data on each detected falling edge into an 11-bit frame: start(0), 8 data LSB first, odd parity, stop(1).
REQ-013 SHALL use a 4-bit bit counter (0..10) that returns to 0 after bit 10.
REQ-014 SHALL accept a frame only if start=0, stop=1 and the XOR of the 8 data bits and parity bit is 1.
REQ-015 SHALL, for an accepted frame whose stop-bit edge is detected in cycle T, load scan_byte and pulse byte_valid in cycle T+1.
REQ-016 SHALL, for a rejected frame, leave scan_byte unchanged and pulse frame_err in cycle T+1 instead of byte_valid.
REQ-017 SHALL, when the bit counter is nonzero and TIMEOUT_CYCLES consecutive cycles pass with no falling edge, clear the bit counter and pulse frame_err once.
REQ-018 SHALL use a 17-bit timeout counter, cleared on every falling edge and held at 0 while the bit counter is 0.
REQ-019 SHALL run a prefix FSM with states IDLE, EXT, BRK and EXT_BRK, advancing only on byte_valid.
REQ-020 SHALL make these FSM transitions: 0xE0 from any state -> EXT; 0xF0 from IDLE or BRK -> BRK; 0xF0 from EXT or EXT_BRK -> EXT_BRK.
REQ-021 SHALL make any other byte apply its action (REQ-022 to REQ-024) and return the FSM to IDLE.
REQ-022 SHALL apply the byte as a make code (bit <= 1) in IDLE or EXT, and as a break code (bit <= 0) in BRK or EXT_BRK.
REQ-023 SHALL decode non-extended codes (IDLE, BRK) as 0x1D=W, 0x1C=A, 0x1B=S, 0x23=D.
REQ-024 SHALL decode extended codes (EXT, EXT_BRK) as 0x75=Up, 0x6B=Left, 0x72=Down, 0x74=Right.
REQ-025 SHALL ignore any other code, including WASD codes in EXT states, arrow codes in non-extended states, and 0xAA, 0xFA and 0xEE, while still returning the FSM to IDLE.
REQ-026 SHALL update key bits in the cycle after byte_valid, making them visible at T+2.
REQ-027 SHALL keep a bit at 1 on a typematic repeat (repeated make) and keep it at 0 on a break of a key already released.
REQ-028 SHALL let keys change independently, so opposite keys (A and D) may both be 1; resolving that conflict belongs to the mover.
REQ-029 SHALL leave FSM and key state unaffected by a frame error.

Reset
REQ-030 SHALL, when rst_n=0 at posedge clk, clear wsad_down, arrow_down, scan_byte, byte_valid, frame_err, the bit counter, the timeout counter and the shift register, set the FSM to IDLE, and set both synchronizer stages to 1.
REQ-031 SHALL give reset priority over every simultaneous event, discarding any partial frame, including reset asserted mid-frame.

Verification
REQ-032 SHALL be verified by this scenario: frame 0x1D with parity 1 -> byte_valid pulse, scan_byte=0x1D, wsad_down=4'b0001 two cycles after the stop edge.
REQ-033 SHALL be verified by this scenario: frames 0x1D, 0x23, F0, 0x1D -> wsad_down goes 0001, 1001, 1000; no frame_err.
REQ-034 SHALL be verified by this scenario: frames E0, 0x6B, then E0, F0, 0x6B -> arrow_down=0010 then 0000; wsad_down stays 0000 throughout.
REQ-035 SHALL be verified by this scenario: frame 0x1C with even parity -> frame_err pulse, scan_byte and wsad_down unchanged; the next good 0x1C -> wsad_down=0010.
REQ-036 SHALL be verified by this scenario: 4 bits sent then ps2_clk held high for TIMEOUT_CYCLES (run at 200) -> one frame_err pulse; the next full frame 0x1B -> wsad_down=0100.
REQ-037 SHALL be verified by this scenario: rst_n low for one cycle at bit 6 of a frame, with wsad_down=1111 beforehand -> all outputs 0; the remaining bits do not create a byte; the next full frame decodes correctly.
